// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM/WB pipeline register and its load-alignment helper.
// Load func3 codes, control_flow bit positions and default widths live here.
package mem_wb_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int RD_WIDTH_DEF   = 5;
    localparam int CNT_WIDTH_DEF  = 64;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_func3_e;

    // Bit positions inside control_flow_mem.
    localparam int CF_REG_WRITE  = 1;
    localparam int CF_MEM_TO_REG = 0;

    function automatic logic is_half_load(input logic [2:0] func3);
        return (func3 == F3_LH) || (func3 == F3_LHU);
    endfunction

    function automatic logic is_word_load(input logic [2:0] func3);
        return func3 == F3_LW;
    endfunction

endpackage

// File: rtl/mem_wb_load_align.sv
// Combinational load alignment: picks the byte/halfword lane from a word-aligned
// load, sign/zero-extends it and flags addresses that are not naturally aligned.
module load_align
    import mem_wb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [1:0]            off_i,
    input  logic [2:0]            func3_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  misaligned_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = data_i[7:0];
        case (off_i)
            2'd0:    byte_lane = data_i[7:0];
            2'd1:    byte_lane = data_i[15:8];
            2'd2:    byte_lane = data_i[23:16];
            default: byte_lane = data_i[31:24];
        endcase
    end

    // Halfword lane uses only off[1]; misaligned halfwords still read the aligned lane.
    assign half_lane = off_i[1] ? data_i[31:16] : data_i[15:0];

    always_comb begin
        data_o = data_i;
        case (func3_i)
            F3_LB:   data_o = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
            F3_LBU:  data_o = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
            F3_LH:   data_o = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
            F3_LHU:  data_o = {{(DATA_WIDTH-16){1'b0}}, half_lane};
            default: data_o = data_i;
        endcase
    end

    assign misaligned_o = (is_half_load(func3_i) && off_i[0])
                        || (is_word_load(func3_i) && (off_i != 2'd0));

endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register and write-back stage: aligns load data, registers the
// write-back packet, drives the register-file write/forwarding port and counts retirements.
module mem_wb
    import mem_wb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int RD_WIDTH   = RD_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  hold,
    input  logic                  valid_mem,
    input  logic                  ready_go_mem,
    output logic                  allow_in_wb,
    input  logic [DATA_WIDTH-1:0] mem_address_i,
    input  logic [DATA_WIDTH-1:0] mem_read_data_i,
    input  logic                  mem_read_i,
    input  logic [1:0]            control_flow_mem,
    input  logic [RD_WIDTH-1:0]   rd_mem,
    input  logic [2:0]            ins_func3_i,
    output logic                  valid_wb,
    output logic                  rf_we,
    output logic [RD_WIDTH-1:0]   rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  load_misaligned,
    output logic [CNT_WIDTH-1:0]  instret
);

    // Handshake: an instruction moves MEM->WB on a posedge where MEM offers it
    // (valid_mem & ready_go_mem & ~flush) and WB accepts (allow_in_wb). WB finishes
    // in one cycle (ready_go_wb=1), so it only refuses while it holds a valid
    // instruction under hold; it then keeps its contents unchanged.
    logic ready_go_wb;
    logic pipe_valid;
    logic load_en;

    logic                  valid_wb_q, valid_wb_d;
    logic [RD_WIDTH-1:0]   rd_q, rd_d;
    logic                  reg_write_q, reg_write_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  misaligned_q, misaligned_d;
    logic [CNT_WIDTH-1:0]  instret_q, instret_d;

    logic [DATA_WIDTH-1:0] aligned_data;
    logic                  align_misaligned;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_misaligned;

    assign ready_go_wb = 1'b1;
    assign allow_in_wb = ~valid_wb_q | (ready_go_wb & ~hold);
    assign pipe_valid  = valid_mem & ready_go_mem & ~flush;
    assign load_en     = pipe_valid & allow_in_wb;

    load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_align (
        .data_i       (mem_read_data_i),
        .off_i        (mem_address_i[1:0]),
        .func3_i      (ins_func3_i),
        .data_o       (aligned_data),
        .misaligned_o (align_misaligned)
    );

    // Non-load results ride on the address bus.
    assign sel_data       = control_flow_mem[CF_MEM_TO_REG] ? aligned_data : mem_address_i;
    assign sel_misaligned = mem_read_i & align_misaligned;

    always_comb begin
        valid_wb_d   = valid_wb_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        data_d       = data_q;
        misaligned_d = misaligned_q;
        instret_d    = instret_q;

        if (allow_in_wb) begin
            valid_wb_d = pipe_valid;
        end

        if (load_en) begin
            rd_d         = rd_mem;
            reg_write_d  = control_flow_mem[CF_REG_WRITE];
            data_d       = sel_data;
            misaligned_d = sel_misaligned;
        end

        // An instruction retires on the edge it leaves WB; a held one is not counted.
        if (valid_wb_q && !hold) begin
            instret_d = instret_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_wb_q   <= 1'b0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            data_q       <= '0;
            misaligned_q <= 1'b0;
            instret_q    <= '0;
        end else begin
            valid_wb_q   <= valid_wb_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            data_q       <= data_d;
            misaligned_q <= misaligned_d;
            instret_q    <= instret_d;
        end
    end

    assign valid_wb        = valid_wb_q;
    assign rf_we           = valid_wb_q & reg_write_q & (rd_q != '0);
    assign rf_waddr        = rd_q;
    assign rf_wdata        = data_q;
    assign load_misaligned = valid_wb_q & misaligned_q;
    assign instret         = instret_q;

endmodule

// File: tb/tb_mem_wb.sv
// Directed testbench for mem_wb: hand-computed write-back values, hold/flush
// interaction, retirement counting and asynchronous reset.
module tb_mem_wb;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        hold;
    logic        valid_mem;
    logic        ready_go_mem;
    logic        allow_in_wb;
    logic [31:0] mem_address_i;
    logic [31:0] mem_read_data_i;
    logic        mem_read_i;
    logic [1:0]  control_flow_mem;
    logic [4:0]  rd_mem;
    logic [2:0]  ins_func3_i;
    logic        valid_wb;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        load_misaligned;
    logic [63:0] instret;

    int n_cmp = 0;
    int n_err = 0;

    mem_wb #(
        .DATA_WIDTH (32),
        .RD_WIDTH   (5),
        .CNT_WIDTH  (64)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .hold             (hold),
        .valid_mem        (valid_mem),
        .ready_go_mem     (ready_go_mem),
        .allow_in_wb      (allow_in_wb),
        .mem_address_i    (mem_address_i),
        .mem_read_data_i  (mem_read_data_i),
        .mem_read_i       (mem_read_i),
        .control_flow_mem (control_flow_mem),
        .rd_mem           (rd_mem),
        .ins_func3_i      (ins_func3_i),
        .valid_wb         (valid_wb),
        .rf_we            (rf_we),
        .rf_waddr         (rf_waddr),
        .rf_wdata         (rf_wdata),
        .load_misaligned  (load_misaligned),
        .instret          (instret)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input logic v, input logic rgo, input logic fl, input logic hd,
                         input logic [31:0] addr, input logic [31:0] word, input logic mrd,
                         input logic [1:0] cf, input logic [4:0] rd, input logic [2:0] f3);
        valid_mem        = v;
        ready_go_mem     = rgo;
        flush            = fl;
        hold             = hd;
        mem_address_i    = addr;
        mem_read_data_i  = word;
        mem_read_i       = mrd;
        control_flow_mem = cf;
        rd_mem           = rd;
        ins_func3_i      = f3;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 5'd0, 3'b000);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wb(input string tag, input logic v, input logic we, input logic [4:0] wa,
                            input logic [31:0] wd, input logic mis, input logic [63:0] cnt);
        check_eq({tag, ".valid_wb"}, {63'd0, valid_wb}, {63'd0, v});
        check_eq({tag, ".rf_we"}, {63'd0, rf_we}, {63'd0, we});
        check_eq({tag, ".rf_waddr"}, {59'd0, rf_waddr}, {59'd0, wa});
        check_eq({tag, ".rf_wdata"}, {32'd0, rf_wdata}, {32'd0, wd});
        check_eq({tag, ".misaligned"}, {63'd0, load_misaligned}, {63'd0, mis});
        check_eq({tag, ".instret"}, instret, cnt);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        step();
        step();
        check_wb("reset", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 64'd0);
        check_eq("reset.allow_in", {63'd0, allow_in_wb}, 64'd1);
        rst_n = 1'b1;

        // LB at offset 3 of 0x80FF_1234 -> byte 0x80 sign-extended
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1003, 32'h80FF_1234, 1'b1, 2'b11, 5'd7, 3'b000);
        step();
        check_wb("lb", 1'b1, 1'b1, 5'd7, 32'hFFFF_FF80, 1'b0, 64'd0);

        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1003, 32'h80FF_1234, 1'b1, 2'b11, 5'd7, 3'b100);
        step();
        check_wb("lbu", 1'b1, 1'b1, 5'd7, 32'h0000_0080, 1'b0, 64'd1);

        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_2002, 32'h8001_7FFF, 1'b1, 2'b11, 5'd3, 3'b001);
        step();
        check_wb("lh", 1'b1, 1'b1, 5'd3, 32'hFFFF_8001, 1'b0, 64'd2);

        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_2003, 32'h8001_7FFF, 1'b1, 2'b11, 5'd3, 3'b001);
        step();
        check_wb("lh_mis", 1'b1, 1'b1, 5'd3, 32'hFFFF_8001, 1'b1, 64'd3);

        // ALU result to x0: valid but no register write
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'hDEAD_0000, 1'b0, 2'b10, 5'd0, 3'b010);
        step();
        check_wb("alu_x0", 1'b1, 1'b0, 5'd0, 32'h1234_5678, 1'b0, 64'd4);

        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_3000, 32'h8001_7FFF, 1'b1, 2'b11, 5'd4, 3'b101);
        step();
        check_wb("lhu", 1'b1, 1'b1, 5'd4, 32'h0000_7FFF, 1'b0, 64'd5);

        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_3001, 32'h8001_7FFF, 1'b1, 2'b11, 5'd5, 3'b010);
        step();
        check_wb("lw_mis", 1'b1, 1'b1, 5'd5, 32'h8001_7FFF, 1'b1, 64'd6);

        // hold three cycles with a new instruction waiting
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_4000, 32'hDEAD_BEEF, 1'b1, 2'b11, 5'd9, 3'b010);
        #1;
        check_eq("hold.allow_in", {63'd0, allow_in_wb}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_wb("hold", 1'b1, 1'b1, 5'd5, 32'h8001_7FFF, 1'b1, 64'd6);
        end
        hold = 1'b0;
        #1;
        check_eq("release.allow_in", {63'd0, allow_in_wb}, 64'd1);
        step();
        check_wb("release", 1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0, 64'd7);

        // flushed instruction never becomes valid
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_5000, 32'h1111_2222, 1'b1, 2'b11, 5'd10, 3'b010);
        step();
        check_eq("flush.valid_wb", {63'd0, valid_wb}, 64'd0);
        check_eq("flush.rf_we", {63'd0, rf_we}, 64'd0);
        check_eq("flush.instret", instret, 64'd8);
        idle();
        step();
        check_eq("flush.instret_after", instret, 64'd8);

        // MEM not ready: bubble
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_6000, 32'h3333_4444, 1'b1, 2'b11, 5'd11, 3'b010);
        step();
        check_eq("bubble.valid_wb", {63'd0, valid_wb}, 64'd0);
        check_eq("bubble.instret", instret, 64'd8);

        // flush during hold is dropped; after release with flush low the instruction enters
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 2'b10, 5'd12, 3'b000);
        step();
        check_wb("pre_fh", 1'b1, 1'b1, 5'd12, 32'h0000_0010, 1'b0, 64'd8);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'h0, 1'b0, 2'b10, 5'd13, 3'b000);
        step();
        check_wb("flush_hold", 1'b1, 1'b1, 5'd12, 32'h0000_0010, 1'b0, 64'd8);
        flush = 1'b0;
        hold  = 1'b0;
        step();
        check_wb("fh_release", 1'b1, 1'b1, 5'd13, 32'h0000_0020, 1'b0, 64'd9);

        // asynchronous reset mid-hold, checked before the next clock edge
        hold = 1'b1;
        step();
        check_wb("pre_rst", 1'b1, 1'b1, 5'd13, 32'h0000_0020, 1'b0, 64'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check_wb("async_rst", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 64'd0);
        idle();
        step();
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
